// File: rtl/game_pkg.sv
// Geometry and pipe record shared by the scroller, renderer and bird logic.
package game_pkg;

    localparam int SCREEN_W  = 320;
    localparam int PIPE_W    = 32;
    localparam int GAP_H     = 64;
    localparam int BIRD_SIZE = 16;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] gap_y;
    } pipe_t;

endpackage

// File: rtl/pipes_scroller_pkg.sv
// Scroller-local types, default tuning values and the LFSR step function.
package pipes_scroller_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, ITER, SPAWN, DONE} state_t;

    localparam int DEF_GAP_MIN      = 32;
    localparam int DEF_SPEED        = 2;
    localparam int DEF_SPAWN_PERIOD = 90;
    localparam int DEF_MAX_PIPES    = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form with taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/pipes_scroller_lfsr16.sv
// 16-bit LFSR that steps only on request; exposes its low OUT_W bits.
module lfsr16
    import pipes_scroller_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             step,
    output logic [OUT_W-1:0] out
);

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (ce && step) begin
            state <= lfsr_next(state);
        end
    end

    assign out = state[OUT_W-1:0];

endmodule

// File: rtl/pipes_scroller.sv
// Per-frame walker over pipes_list: scrolls, culls, scores and collides pipes,
// then spawns a new pipe on a fixed frame period.
module pipes_scroller
    import game_pkg::*, pipes_scroller_pkg::*;
#(
    parameter int GAP_MIN      = DEF_GAP_MIN,
    parameter int SPEED        = DEF_SPEED,
    parameter int SPAWN_PERIOD = DEF_SPAWN_PERIOD,
    parameter int MAX_PIPES    = DEF_MAX_PIPES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       frame_start,
    input  logic [9:0] bird_x,
    input  logic [9:0] bird_y,
    input  logic [4:0] list_count,
    output logic       insert_en,
    output pipe_t      insert_data,
    output logic       iter_start,
    input  logic       iter_done,
    input  pipe_t      iter_out,
    output pipe_t      iter_in,
    output logic       iter_remove,
    output logic       busy,
    output logic       frame_done,
    output logic       collision,
    output logic [7:0] score,
    output logic       overrun
);

    localparam logic [10:0] PW = 11'(PIPE_W);
    localparam logic [10:0] GH = 11'(GAP_H);
    localparam logic [10:0] BS = 11'(BIRD_SIZE);
    localparam logic [10:0] SP = 11'(SPEED);

    state_t     state;
    logic       collision_acc;
    logic [7:0] spawn_cnt;
    logic [6:0] lfsr_low;
    logic       do_insert;
    logic       hit;
    logic       passed;

    logic [10:0] x11, gy11, bx11, by11;

    assign x11  = {1'b0, iter_out.x};
    assign gy11 = {1'b0, iter_out.gap_y};
    assign bx11 = {1'b0, bird_x};
    assign by11 = {1'b0, bird_y};

    assign do_insert = (spawn_cnt >= 8'(SPAWN_PERIOD)) && (list_count < 5'(MAX_PIPES));

    lfsr16 #(.OUT_W(7)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .step  ((state == ITER) && iter_done && do_insert),
        .out   (lfsr_low)
    );

    // The LFSR steps on entry to SPAWN, so the inserted gap uses the stepped value.
    assign insert_data = '{x: 10'(SCREEN_W), gap_y: 10'(GAP_MIN) + {3'b000, lfsr_low}};

    always_comb begin
        iter_in     = iter_out;
        iter_remove = 1'b0;
        hit         = 1'b0;
        passed      = 1'b0;
        if (state == ITER && !iter_done) begin
            iter_remove = x11 < SP;
            iter_in.x   = iter_out.x - 10'(SPEED);
            hit         = (bx11 + BS > x11) && (bx11 < x11 + PW) &&
                          ((by11 < gy11) || (by11 + BS > gy11 + GH));
            passed      = (x11 + PW >= bx11) && (x11 + PW - SP < bx11);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            collision     <= 1'b0;
            score         <= 8'd0;
            overrun       <= 1'b0;
            insert_en     <= 1'b0;
            iter_start    <= 1'b0;
            collision_acc <= 1'b0;
            spawn_cnt     <= 8'd0;
        end else if (ce) begin
            iter_start <= 1'b0;
            insert_en  <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state         <= START;
                        busy          <= 1'b1;
                        iter_start    <= 1'b1;
                        collision_acc <= 1'b0;
                        if (spawn_cnt != 8'hFF) begin
                            spawn_cnt <= spawn_cnt + 8'd1;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT:  state <= ITER;
                ITER: begin
                    if (iter_done) begin
                        state     <= SPAWN;
                        insert_en <= do_insert;
                    end else begin
                        if (hit) begin
                            collision_acc <= 1'b1;
                        end
                        if (passed && score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end
                end
                SPAWN: begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                    collision  <= collision_acc;
                    if (insert_en) begin
                        spawn_cnt <= 8'd0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipes_scroller.sv
// Drives pipes_scroller against a behavioural pipes_list and a per-frame game model.
module tb_pipes_scroller;
    import game_pkg::*;

    localparam int SPAWN_P = 3;
    localparam int MAXP    = 16;
    localparam int SPEED   = 2;
    localparam int GAP_MIN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ce, frame_start;
    logic [9:0] bird_x, bird_y;
    logic [4:0] list_count;
    logic       insert_en, iter_start, iter_done, iter_remove;
    logic       busy, frame_done, collision, overrun;
    logic [7:0] score;
    pipe_t      insert_data, iter_out, iter_in;

    pipes_scroller #(.SPAWN_PERIOD(SPAWN_P)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .frame_start(frame_start),
        .bird_x(bird_x), .bird_y(bird_y), .list_count(list_count),
        .insert_en(insert_en), .insert_data(insert_data), .iter_start(iter_start),
        .iter_done(iter_done), .iter_out(iter_out), .iter_in(iter_in),
        .iter_remove(iter_remove), .busy(busy), .frame_done(frame_done),
        .collision(collision), .score(score), .overrun(overrun)
    );

    int checks = 0;
    int passes = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural pipes_list: one settle cycle after iter_start, then one element per enabled cycle.
    pipe_t mem [32];
    pipe_t load_buf [MAXP];
    int    load_n;
    logic  load_req;
    int    cnt, rd, wr, wn;
    logic  walking, armed;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < MAXP; i++) mem[i] <= load_buf[i];
            cnt <= load_n; walking <= 1'b0; armed <= 1'b0;
        end else if (!rst_n) begin
            cnt <= 0; walking <= 1'b0; armed <= 1'b0; rd <= 0; wr <= 0; wn <= 0;
        end else if (ce) begin
            armed <= iter_start;
            if (armed) begin
                walking <= 1'b1; rd <= 0; wr <= 0; wn <= cnt;
            end else if (walking) begin
                if (rd < wn) begin
                    if (iter_remove) cnt <= cnt - 1;
                    else begin mem[wr] <= iter_in; wr <= wr + 1; end
                    rd <= rd + 1;
                end else walking <= 1'b0;
            end
            if (insert_en) begin mem[cnt] <= insert_data; cnt <= cnt + 1; end
        end
    end

    assign iter_done  = !(walking && rd < wn);
    assign iter_out   = (walking && rd < wn) ? mem[rd] : '0;
    assign list_count = cnt[4:0];

    // Game-level model state
    int         m_score, m_spawn;
    logic [15:0] m_lfsr;
    logic       m_overrun;

    function automatic logic [15:0] model_lfsr(input logic [15:0] v);
        int taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[t]) fb = fb ^ v[16 - taps[t]];
        return {fb, v[15:1]};
    endfunction

    task automatic load_list(input int n, input int xs [MAXP], input int gs [MAXP]);
        for (int i = 0; i < MAXP; i++) load_buf[i] = '{x: 10'(xs[i]), gap_y: 10'(gs[i])};
        load_n = n; load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; ce = 1'b1; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_frame_done", int'(frame_done), 0);
        check_output("rst_collision", int'(collision), 0);
        check_output("rst_score", int'(score), 0);
        check_output("rst_overrun", int'(overrun), 0);
        check_output("rst_insert_en", int'(insert_en), 0);
        check_output("rst_iter_start", int'(iter_start), 0);
        check_output("rst_iter_remove", int'(iter_remove), 0);
        rst_n = 1'b1;
        m_score = 0; m_spawn = 0; m_lfsr = 16'hACE1; m_overrun = 1'b0;
    endtask

    task automatic apply_stimulus(input bit gaps, input int ovr_k, output int done_k);
        pipe_t snap[$];
        pipe_t expl[$];
        pipe_t ins;
        int    n, k, cyc, pf, x, gy, bx, by;
        bit    exp_col, do_ins, ovr_sent, rem;
        n = cnt;
        for (int i = 0; i < n; i++) snap.push_back(mem[i]);
        bx = int'(bird_x); by = int'(bird_y);
        exp_col = 1'b0; pf = 0;
        foreach (snap[i]) begin
            x = int'(snap[i].x); gy = int'(snap[i].gap_y);
            if (bx + BIRD_SIZE > x && bx < x + PIPE_W && (by < gy || by + BIRD_SIZE > gy + GAP_H))
                exp_col = 1'b1;
            if (x + PIPE_W >= bx && x - SPEED + PIPE_W < bx) pf++;
            if (x >= SPEED) expl.push_back('{x: 10'(x - SPEED), gap_y: snap[i].gap_y});
        end
        m_score = (m_score + pf > 255) ? 255 : m_score + pf;
        if (m_spawn < 255) m_spawn++;
        do_ins = (m_spawn >= SPAWN_P) && (expl.size() < MAXP);
        ins = '0;
        if (do_ins) begin
            m_lfsr = model_lfsr(m_lfsr);
            ins = '{x: 10'(SCREEN_W), gap_y: 10'(GAP_MIN + int'(m_lfsr[6:0]))};
            expl.push_back(ins);
            m_spawn = 0;
        end
        if (ovr_k > 0) m_overrun = 1'b1;

        frame_start = 1'b1; ce = 1'b1;
        k = 0; cyc = 0; done_k = -1; ovr_sent = 1'b0;
        while (1) begin
            @(posedge clk);
            if (ce) k++;
            #1;
            frame_start = 1'b0;
            ce = gaps ? (cyc % 3 != 1) : 1'b1;
            if (ovr_k > 0 && k == ovr_k && !ovr_sent) begin
                frame_start = 1'b1; ce = 1'b1; ovr_sent = 1'b1;
            end
            cyc++;
            #1;
            check_output("busy", int'(busy), int'(k >= 1 && k <= n + 5));
            check_output("iter_start", int'(iter_start), int'(k == 1));
            check_output("frame_done", int'(frame_done), int'(k == n + 5));
            check_output("insert_en", int'(insert_en), int'(k == n + 4 && do_ins));
            if (k == n + 4 && do_ins) begin
                check_output("insert_x", int'(insert_data.x), int'(ins.x));
                check_output("insert_gap", int'(insert_data.gap_y), int'(ins.gap_y));
            end
            if (k >= 3 && k <= n + 2) begin
                rem = snap[k-3].x < SPEED;
                check_output("iter_remove", int'(iter_remove), int'(rem));
                if (!rem) begin
                    check_output("iter_in_x", int'(iter_in.x), int'(snap[k-3].x) - SPEED);
                    check_output("iter_in_gap", int'(iter_in.gap_y), int'(snap[k-3].gap_y));
                end
            end else begin
                check_output("iter_remove_idle", int'(iter_remove), 0);
            end
            if (k == n + 5) begin
                done_k = k;
                check_output("collision", int'(collision), int'(exp_col));
                check_output("score", int'(score), m_score);
            end
            if (k == n + 6) break;
            if (cyc > 300) begin
                $display("[TB] FAIL frame_timeout: got no frame end after %0d cycles, expected %0d", cyc, n + 6);
                checks++;
                break;
            end
        end
        frame_start = 1'b0; ce = 1'b1;
        check_output("list_count", cnt, expl.size());
        foreach (expl[i]) begin
            if (i < cnt) begin
                check_output("list_x", int'(mem[i].x), int'(expl[i].x));
                check_output("list_gap", int'(mem[i].gap_y), int'(expl[i].gap_y));
            end
        end
        check_output("overrun", int'(overrun), int'(m_overrun));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int xs [MAXP];
        int gs [MAXP];
        int dk;
        rst_n = 1'b0; ce = 1'b1; frame_start = 1'b0; load_req = 1'b0; load_n = 0;
        bird_x = 10'd200; bird_y = 10'd300;
        @(posedge clk); #1;
        apply_reset();

        // Empty list: spawn lands on the third frame with the first stepped LFSR value.
        apply_stimulus(0, 0, dk);
        check_output("empty_latency", dk, 5);
        apply_stimulus(0, 0, dk);
        apply_stimulus(0, 0, dk);
        check_output("spawn_count", cnt, 1);
        check_output("spawn_x", int'(mem[0].x), 320);
        check_output("spawn_gap", int'(mem[0].gap_y), 144);

        xs = '{default: 0}; gs = '{default: 80};
        xs[0] = 100; xs[1] = 150; xs[2] = 200;
        load_list(3, xs, gs);
        apply_stimulus(0, 0, dk);
        check_output("three_latency", dk, 8);
        check_output("three_x0", int'(mem[0].x), 98);
        check_output("three_x1", int'(mem[1].x), 148);
        check_output("three_x2", int'(mem[2].x), 198);

        xs[0] = 1; xs[1] = 50;
        load_list(2, xs, gs);
        apply_stimulus(0, 0, dk);
        check_output("cull_count", cnt, 1);
        check_output("cull_x", int'(mem[0].x), 48);

        bird_x = 10'd40; bird_y = 10'd10;
        xs[0] = 30; gs[0] = 100;
        load_list(1, xs, gs);
        apply_stimulus(0, 0, dk);
        check_output("collide_hit", int'(collision), 1);
        gs[0] = 0;
        load_list(1, xs, gs);
        apply_stimulus(0, 0, dk);
        check_output("collide_clear", int'(collision), 0);

        bird_x = 10'd200; bird_y = 10'd300;
        xs[0] = 60; gs[0] = 70; xs[1] = 1; gs[1] = 90; xs[2] = 300; gs[2] = 40;
        load_list(3, xs, gs);
        apply_stimulus(1, 0, dk);

        // Reset in the middle of the walk.
        load_list(3, xs, gs);
        frame_start = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();
        apply_stimulus(0, 0, dk);

        bird_x = 10'd43; bird_y = 10'd120;
        xs[0] = 12; gs[0] = 100;
        load_list(1, xs, gs);
        apply_stimulus(0, 0, dk);
        check_output("pass_score", int'(score), 1);
        xs[0] = 10;
        load_list(1, xs, gs);
        apply_stimulus(0, 0, dk);

        xs = '{default: 12}; gs = '{default: 100};
        for (int f = 0; f < 16; f++) begin
            load_list(16, xs, gs);
            apply_stimulus(0, 0, dk);
        end
        check_output("score_sat", int'(score), 255);
        check_output("full_no_insert", cnt, 16);

        xs[0] = 200;
        load_list(1, xs, gs);
        apply_stimulus(0, 0, dk);
        check_output("held_spawn", cnt, 2);

        xs[0] = 100; xs[1] = 150; xs[2] = 200;
        load_list(3, xs, gs);
        apply_stimulus(0, 4, dk);
        check_output("overrun_set", int'(overrun), 1);
        apply_stimulus(0, 0, dk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
